// File: rtl/cpu_jtag_debug_scan_master.sv
// cpu_jtag_debug_scan_master
// On-chip initiator for the CPU debug module's virtual-JTAG slave port.
// One accepted command (IR value + DR word) becomes a full scan:
// UIR -> CDR -> SDR x DR_WIDTH -> UDR -> RTI, then the captured DR bits
// are returned on the response channel. tck is generated from clk; each
// scan period is TCK_DIV clks low followed by TCK_DIV clks high.
// DR_WIDTH must be at least 2.

module cpu_jtag_debug_scan_master #(
    parameter int DR_WIDTH     = 38,
    parameter int IR_WIDTH     = 2,
    parameter int TCK_DIV      = 4,
    parameter bit SKIP_SAME_IR = 1'b1
) (
    input  logic                clk,
    input  logic                reset_n,
    // command channel
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [IR_WIDTH-1:0] cmd_ir,
    input  logic [DR_WIDTH-1:0] cmd_dr,
    // response channel
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DR_WIDTH-1:0] rsp_data,
    output logic [IR_WIDTH-1:0] rsp_ir_out,
    // virtual-JTAG slave side
    output logic                tck,
    output logic                tdi,
    input  logic                tdo,
    output logic [IR_WIDTH-1:0] ir_in,
    input  logic [IR_WIDTH-1:0] ir_out,
    output logic                vs_uir,
    output logic                vs_cdr,
    output logic                vs_sdr,
    output logic                vs_udr,
    output logic                jtag_state_rti
);

    // Divider counts 0 .. 2*TCK_DIV-1 across one tck period.
    localparam int DIV_W = (2 * TCK_DIV > 2) ? $clog2(2 * TCK_DIV) : 1;
    localparam int CNT_W = (DR_WIDTH > 2) ? $clog2(DR_WIDTH) : 1;

    localparam logic [DIV_W-1:0] DIV_RISE = DIV_W'(TCK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(2 * TCK_DIV - 1);
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(DR_WIDTH - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_UIR,
        ST_CDR,
        ST_SDR,
        ST_UDR,
        ST_RTI
    } state_t;

    state_t              state_reg;
    logic [DIV_W-1:0]    div_cnt_reg;
    logic [CNT_W-1:0]    bit_cnt_reg;
    logic [DR_WIDTH-1:0] dr_shift_reg;
    logic                ir_loaded_reg;

    logic                accept;
    logic                skip_uir;
    logic                tck_rise;
    logic                period_end;

    // Handshake and period-phase decodes shared by the sequencer.
    always_comb begin
        accept     = cmd_valid && cmd_ready;
        skip_uir   = SKIP_SAME_IR && ir_loaded_reg && (cmd_ir == ir_in);
        tck_rise   = (div_cnt_reg == DIV_RISE);
        period_end = (div_cnt_reg == DIV_LAST);
    end

    // Scan sequencer: state, tck divider, serial data and all registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= ST_IDLE;
            div_cnt_reg    <= '0;
            bit_cnt_reg    <= '0;
            dr_shift_reg   <= '0;
            ir_loaded_reg  <= 1'b0;
            tck            <= 1'b0;
            tdi            <= 1'b0;
            ir_in          <= '0;
            vs_uir         <= 1'b0;
            vs_cdr         <= 1'b0;
            vs_sdr         <= 1'b0;
            vs_udr         <= 1'b0;
            jtag_state_rti <= 1'b1;
            cmd_ready      <= 1'b1;
            rsp_valid      <= 1'b0;
            rsp_data       <= '0;
            rsp_ir_out     <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (rsp_valid && rsp_ready) begin
                        rsp_valid <= 1'b0;
                    end
                    if (accept) begin
                        cmd_ready      <= 1'b0;
                        jtag_state_rti <= 1'b0;
                        div_cnt_reg    <= '0;
                        tck            <= 1'b0;
                        dr_shift_reg   <= cmd_dr;
                        if (skip_uir) begin
                            // Slave already holds this instruction.
                            state_reg <= ST_CDR;
                            vs_cdr    <= 1'b1;
                        end else begin
                            // New IR is visible from the first clk of UIR.
                            state_reg     <= ST_UIR;
                            vs_uir        <= 1'b1;
                            ir_in         <= cmd_ir;
                            ir_loaded_reg <= 1'b1;
                        end
                    end else begin
                        // Ready only once an outstanding response has drained.
                        cmd_ready <= !rsp_valid;
                    end
                end

                default: begin
                    if (tck_rise) begin
                        // Mid-period: tck rises; the slave's tdo is sampled here,
                        // before the slave shifts on this same rising edge.
                        tck         <= 1'b1;
                        div_cnt_reg <= div_cnt_reg + 1'b1;
                        if (state_reg == ST_CDR) begin
                            rsp_ir_out <= ir_out;
                        end
                        if (state_reg == ST_SDR) begin
                            // First bit shifted ends up at the LSB after DR_WIDTH samples.
                            rsp_data <= {tdo, rsp_data[DR_WIDTH-1:1]};
                        end
                    end else if (period_end) begin
                        // End of period: tck falls and the next state begins.
                        tck         <= 1'b0;
                        div_cnt_reg <= '0;
                        case (state_reg)
                            ST_UIR: begin
                                state_reg <= ST_CDR;
                                vs_uir    <= 1'b0;
                                vs_cdr    <= 1'b1;
                            end
                            ST_CDR: begin
                                state_reg    <= ST_SDR;
                                vs_cdr       <= 1'b0;
                                vs_sdr       <= 1'b1;
                                bit_cnt_reg  <= '0;
                                tdi          <= dr_shift_reg[0];
                                dr_shift_reg <= dr_shift_reg >> 1;
                            end
                            ST_SDR: begin
                                if (bit_cnt_reg == BIT_LAST) begin
                                    state_reg   <= ST_UDR;
                                    vs_sdr      <= 1'b0;
                                    vs_udr      <= 1'b1;
                                    bit_cnt_reg <= '0;
                                    tdi         <= 1'b0;
                                end else begin
                                    bit_cnt_reg  <= bit_cnt_reg + 1'b1;
                                    tdi          <= dr_shift_reg[0];
                                    dr_shift_reg <= dr_shift_reg >> 1;
                                end
                            end
                            ST_UDR: begin
                                state_reg      <= ST_RTI;
                                vs_udr         <= 1'b0;
                                jtag_state_rti <= 1'b1;
                            end
                            ST_RTI: begin
                                // Response appears on the first IDLE clk.
                                state_reg <= ST_IDLE;
                                rsp_valid <= 1'b1;
                            end
                            default: begin
                                state_reg <= ST_IDLE;
                            end
                        endcase
                    end else begin
                        div_cnt_reg <= div_cnt_reg + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_jtag_debug_scan_master.sv
// Bench for cpu_jtag_debug_scan_master: a period-level model of the scan
// sequence is compared against the DUT on every clk, with directed commands
// and hand-computed literal expectations for latency, pulse widths and data.

module tb_cpu_jtag_debug_scan_master;

    localparam int W  = 38;
    localparam int IW = 2;
    localparam int D  = 4;
    localparam logic [W-1:0] PRE = 38'h2A_AAAA_AAAA;

    logic clk = 1'b0;
    logic reset_n = 1'b1;

    // DUT with TCK_DIV = 4
    logic          cmd_valid = 1'b0, cmd_ready;
    logic [IW-1:0] cmd_ir = '0;
    logic [W-1:0]  cmd_dr = '0;
    logic          rsp_valid, rsp_ready = 1'b1;
    logic [W-1:0]  rsp_data;
    logic [IW-1:0] rsp_ir_out;
    logic          tck, tdi, tdo;
    logic [IW-1:0] ir_in;
    logic [IW-1:0] ir_out = '0;
    logic          vs_uir, vs_cdr, vs_sdr, vs_udr, jtag_state_rti;

    // DUT with TCK_DIV = 1
    logic          cmd_valid1 = 1'b0, cmd_ready1;
    logic [IW-1:0] cmd_ir1 = '0;
    logic [W-1:0]  cmd_dr1 = '0;
    logic          rsp_valid1, rsp_ready1 = 1'b1;
    logic [W-1:0]  rsp_data1;
    logic [IW-1:0] rsp_ir_out1;
    logic          tck1, tdi1, tdo1;
    logic [IW-1:0] ir_in1;
    logic [IW-1:0] ir_out1 = '0;
    logic          vs_uir1, vs_cdr1, vs_sdr1, vs_udr1, jtag_state_rti1;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    cpu_jtag_debug_scan_master #(.DR_WIDTH(W), .IR_WIDTH(IW), .TCK_DIV(D), .SKIP_SAME_IR(1'b1)) dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ir(cmd_ir), .cmd_dr(cmd_dr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_ir_out(rsp_ir_out),
        .tck(tck), .tdi(tdi), .tdo(tdo), .ir_in(ir_in), .ir_out(ir_out),
        .vs_uir(vs_uir), .vs_cdr(vs_cdr), .vs_sdr(vs_sdr), .vs_udr(vs_udr),
        .jtag_state_rti(jtag_state_rti)
    );

    cpu_jtag_debug_scan_master #(.DR_WIDTH(W), .IR_WIDTH(IW), .TCK_DIV(1), .SKIP_SAME_IR(1'b1)) dut1 (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready1), .cmd_ir(cmd_ir1), .cmd_dr(cmd_dr1),
        .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1), .rsp_data(rsp_data1), .rsp_ir_out(rsp_ir_out1),
        .tck(tck1), .tdi(tdi1), .tdo(tdo1), .ir_in(ir_in1), .ir_out(ir_out1),
        .vs_uir(vs_uir1), .vs_cdr(vs_cdr1), .vs_sdr(vs_sdr1), .vs_udr(vs_udr1),
        .jtag_state_rti(jtag_state_rti1)
    );

    // Virtual-JTAG slave data registers: shift on tck rise during SDR.
    logic [W-1:0] slave, slave1;
    assign tdo  = slave[0];
    assign tdo1 = slave1[0];

    always @(posedge tck or negedge reset_n) begin
        if (!reset_n)    slave <= PRE;
        else if (vs_sdr) slave <= {tdi, slave[W-1:1]};
    end

    always @(posedge tck1 or negedge reset_n) begin
        if (!reset_n)     slave1 <= PRE;
        else if (vs_sdr1) slave1 <= {tdi1, slave1[W-1:1]};
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model (period level) ----------------
    int            cyc = 0;
    int            m_acc = 0;
    int            m_acc_cnt = 0;
    logic          m_busy = 1'b0, m_skip = 1'b0, m_ir_loaded = 1'b0;
    logic          m_rsp_valid = 1'b0, m_ready = 1'b1;
    logic [IW-1:0] m_ir = '0, m_rsp_ir = '0;
    logic [W-1:0]  m_dr = '0, m_rsp_data = '0, m_slave = PRE;

    always @(posedge clk or negedge reset_n) begin : model
        logic pre_busy, pre_rv, acc;
        if (!reset_n) begin
            m_busy = 1'b0; m_skip = 1'b0; m_ir_loaded = 1'b0;
            m_rsp_valid = 1'b0; m_ready = 1'b1;
            m_ir = '0; m_rsp_ir = '0; m_rsp_data = '0; m_slave = PRE; m_dr = '0;
        end else begin
            cyc = cyc + 1;
            pre_busy = m_busy;
            pre_rv   = m_rsp_valid;
            acc      = m_ready && cmd_valid;
            if (m_busy && (cyc - m_acc) == (m_skip ? W + 3 : W + 4) * 2 * D) begin
                m_busy = 1'b0;
                m_rsp_valid = 1'b1;
            end else if (pre_rv && rsp_ready) begin
                m_rsp_valid = 1'b0;
            end
            if (acc) begin
                m_busy = 1'b1;
                m_acc = cyc;
                m_acc_cnt = m_acc_cnt + 1;
                m_skip = m_ir_loaded && (cmd_ir == m_ir);
                if (!m_skip) begin
                    m_ir = cmd_ir;
                    m_ir_loaded = 1'b1;
                end
                m_dr = cmd_dr;
                m_rsp_data = m_slave;
                m_slave = cmd_dr;
                m_rsp_ir = ir_out;
            end
            m_ready = !pre_busy && !pre_rv && !acc;
        end
    end

    // Per-clk comparison of every DUT output against the model.
    always @(negedge clk) begin : compare
        logic [10:0] e;
        logic [3:0]  vs;
        logic        t, di;
        int          k, p, q, p0;
        if (!m_busy) begin
            e = {1'b0, 1'b0, m_ir, 4'b0000, 1'b1, m_ready, m_rsp_valid};
        end else begin
            k  = cyc - m_acc;
            p  = k / (2 * D);
            q  = k % (2 * D);
            p0 = m_skip ? 1 : 2;
            t  = (q >= D);
            di = (p >= p0 && p < p0 + W) ? m_dr[p - p0] : 1'b0;
            vs = {(!m_skip && p == 0), (p == p0 - 1), (p >= p0 && p < p0 + W), (p == p0 + W)};
            e  = {t, di, m_ir, vs, (p == p0 + W + 1), 1'b0, 1'b0};
        end
        check("outputs", 64'({tck, tdi, ir_in, vs_uir, vs_cdr, vs_sdr, vs_udr,
                              jtag_state_rti, cmd_ready, rsp_valid}), 64'(e));
        if (m_rsp_valid) begin
            check("rsp_data", 64'(rsp_data), 64'(m_rsp_data));
            check("rsp_ir_out", 64'(rsp_ir_out), 64'(m_rsp_ir));
        end
    end

    // Per-transaction measurements: pulse widths and response latency.
    int            mon_seen = 0;
    int            uir_cnt = 0, sdr_cnt = 0, lat = 0;
    logic          rv_seen = 1'b0;
    logic [IW-1:0] uir_ir = '0;

    always @(negedge clk) begin : monitor
        if (m_acc_cnt != mon_seen) begin
            mon_seen = m_acc_cnt;
            uir_cnt = 0; sdr_cnt = 0; rv_seen = 1'b0; lat = -1; uir_ir = '0;
        end
        if (vs_uir) begin
            if (uir_cnt == 0) uir_ir = ir_in;
            uir_cnt++;
        end
        if (vs_sdr) sdr_cnt++;
        if (rsp_valid && !rv_seen) begin
            rv_seen = 1'b1;
            lat = cyc - m_acc;
        end
    end

    task automatic send_cmd(input logic [IW-1:0] ir, input logic [W-1:0] dr, input logic [IW-1:0] iro);
        int start;
        bit done;
        @(negedge clk);
        cmd_ir = ir; cmd_dr = dr; ir_out = iro; cmd_valid = 1'b1;
        start = m_acc_cnt;
        done = 1'b0;
        for (int i = 0; i < 2000 && !done; i++) begin
            @(negedge clk);
            if (m_acc_cnt != start) done = 1'b1;
        end
        cmd_valid = 1'b0;
        check("accept_timeout", 64'(done), 64'(1));
    endtask

    task automatic wait_rsp();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 2000 && !done; i++) begin
            @(negedge clk);
            if (rsp_valid) done = 1'b1;
        end
        #1;
        check("rsp_timeout", 64'(done), 64'(1));
        $display("rsp: ir_out=%b data=%h latency=%0d uir_clks=%0d sdr_clks=%0d",
                 rsp_ir_out, rsp_data, lat, uir_cnt, sdr_cnt);
    endtask

    task automatic check_reset(input string name);
        check({name, "_outs"}, 64'({tck, tdi, ir_in, vs_uir, vs_cdr, vs_sdr, vs_udr,
                                    jtag_state_rti, cmd_ready, rsp_valid}), 64'(11'b000_0000_0110));
        check({name, "_data"}, 64'(rsp_data), 64'(0));
        check({name, "_irout"}, 64'(rsp_ir_out), 64'(0));
        check({name, "_dut1"}, 64'({tck1, jtag_state_rti1, cmd_ready1, rsp_valid1}), 64'(4'b0110));
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int accs;
        bit done;
        int cnt1;
        #1 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Reset while idle, checked right at the asynchronous edge.
        #2 reset_n = 1'b0;
        #1 check_reset("rst_idle");
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Full scan with UIR.
        send_cmd(2'b01, 38'h0_1234_5678, 2'b11);
        wait_rsp();
        check("A_latency", 64'(lat), 64'd336);
        check("A_sdr_clks", 64'(sdr_cnt), 64'd304);
        check("A_uir_clks", 64'(uir_cnt), 64'd8);
        check("A_rsp_data", 64'(rsp_data), 64'(38'h2A_AAAA_AAAA));
        check("A_rsp_ir_out", 64'(rsp_ir_out), 64'(2'b11));
        check("A_slave", 64'(slave), 64'(38'h0_1234_5678));

        // Same IR: UIR skipped.
        send_cmd(2'b01, 38'h3F_0000_FFFF, 2'b01);
        wait_rsp();
        check("B_latency", 64'(lat), 64'd328);
        check("B_uir_clks", 64'(uir_cnt), 64'd0);
        check("B_rsp_data", 64'(rsp_data), 64'(38'h0_1234_5678));

        // New IR: UIR present, response held back by rsp_ready.
        send_cmd(2'b10, 38'h15_5555_5555, 2'b10);
        rsp_ready = 1'b0;
        wait_rsp();
        check("C_latency", 64'(lat), 64'd336);
        check("C_uir_clks", 64'(uir_cnt), 64'd8);
        check("C_uir_ir_in", 64'(uir_ir), 64'(2'b10));
        check("C_rsp_data", 64'(rsp_data), 64'(38'h3F_0000_FFFF));

        // Command offered while the response is pending must wait.
        cmd_ir = 2'b01; cmd_dr = 38'h0_0F0F_0F0F; ir_out = 2'b01; cmd_valid = 1'b1;
        accs = m_acc_cnt;
        repeat (20) @(negedge clk);
        #1;
        check("hold_rsp_valid", 64'({rsp_valid, cmd_ready}), 64'(2'b10));
        check("hold_rsp_data", 64'(rsp_data), 64'(38'h3F_0000_FFFF));
        rsp_ready = 1'b1;
        @(negedge clk);
        #1 check("after_hs", 64'({rsp_valid, cmd_ready}), 64'(2'b00));
        @(negedge clk);
        #1 check("ready_back", 64'(cmd_ready), 64'(1));
        done = 1'b0;
        for (int i = 0; i < 10 && !done; i++) begin
            @(negedge clk);
            if (m_acc_cnt != accs) done = 1'b1;
        end
        cmd_valid = 1'b0;
        check("D_accept", 64'(done), 64'(1));

        // Reset in the middle of SDR while tck is high.
        repeat (85) @(negedge clk);
        #1 check("D_mid_sdr", 64'({tck, vs_sdr}), 64'(2'b11));
        #1 reset_n = 1'b0;
        #1 check_reset("rst_scan");
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // After reset, even IR 0 (equal to reset ir_in) must run UIR.
        send_cmd(2'b00, 38'h2B_CDEF_0123, 2'b10);
        wait_rsp();
        check("E_uir_clks", 64'(uir_cnt), 64'd8);
        check("E_latency", 64'(lat), 64'd336);
        check("E_rsp_data", 64'(rsp_data), 64'(PRE));

        // TCK_DIV = 1 instance.
        @(negedge clk);
        check("F_ready", 64'(cmd_ready1), 64'(1));
        cmd_ir1 = 2'b01; cmd_dr1 = 38'h0_1234_5678; cmd_valid1 = 1'b1;
        @(negedge clk);
        cmd_valid1 = 1'b0;
        cnt1 = 0;
        for (int k = 0; k < 84; k++) begin
            check("F_tck", 64'({tck1, cmd_ready1, rsp_valid1}), 64'({(k % 2 == 1), 2'b00}));
            if (vs_sdr1) cnt1++;
            @(negedge clk);
        end
        check("F_rsp_valid", 64'(rsp_valid1), 64'(1));
        check("F_rsp_data", 64'(rsp_data1), 64'(PRE));
        check("F_sdr_clks", 64'(cnt1), 64'd76);
        $display("rsp1: data=%h sdr_clks=%0d", rsp_data1, cnt1);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
